// File: rtl/tl_d_resp_buffer.sv
// TileLink-UL D-channel response buffer.
// Checks each D beat against an outstanding-source table filled by accepted
// A requests, buffers legal responses in a DEPTH-entry FIFO and presents them
// to the upstream master with valid/ready. Illegal beats are dropped and flagged.
module tl_d_resp_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SRC_W  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // A-channel request tracking
  input  logic                      a_fire,
  input  logic [SRC_W-1:0]          a_source,
  output logic                      a_src_busy,
  // D-channel from slave
  input  logic                      d_valid,
  output logic                      d_ready,
  input  logic [2:0]                d_opcode,
  input  logic [SRC_W-1:0]          d_source,
  input  logic [DATA_W-1:0]         d_data,
  input  logic                      d_denied,
  input  logic                      d_corrupt,
  // Response toward master
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [2:0]                rsp_opcode,
  output logic [SRC_W-1:0]          rsp_source,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_denied,
  output logic                      rsp_corrupt,
  // Status
  output logic [$clog2(DEPTH):0]    count,
  output logic [(2**SRC_W)-1:0]     pend,
  output logic                      err_pulse,
  output logic                      err_sticky,
  input  logic                      err_clr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NSRC  = 2 ** SRC_W;

  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [SRC_W-1:0]  source;
    logic [DATA_W-1:0] data;
    logic              denied;
    logic              corrupt;
  } entry_t;

  // Registered state
  entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [NSRC-1:0]   r_pend;
  logic              r_err_pulse;
  logic              r_err_sticky;

  // Combinational handshake / classification
  logic              w_full;
  logic              w_empty;
  logic              w_d_acc;
  logic              w_op_ok;
  logic              w_legal;
  logic              w_illegal;
  logic              w_deq;
  logic              w_same_src_clear;
  logic              w_dup;
  logic              w_err;
  logic [NSRC-1:0]   w_pend_nxt;
  entry_t            w_din;
  entry_t            w_head;

  // Full/empty come only from the registered count, so d_ready has no input path
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == CNT_W'(0));

  assign d_ready   = !w_full;
  assign rsp_valid = !w_empty;

  // A beat is legal only for an outstanding source with an AccessAck/AccessAckData opcode
  assign w_d_acc   = d_valid && d_ready;
  assign w_op_ok   = (d_opcode == OP_ACCESS_ACK) || (d_opcode == OP_ACCESS_ACK_DATA);
  assign w_legal   = w_d_acc && r_pend[d_source] && w_op_ok;
  assign w_illegal = w_d_acc && !w_legal;
  assign w_deq     = rsp_valid && rsp_ready;

  // Re-issuing a source in the cycle its response retires is legal ID reuse
  assign w_same_src_clear = w_legal && (d_source == a_source);
  assign w_dup            = a_fire && r_pend[a_source] && !w_same_src_clear;
  assign w_err            = w_illegal || w_dup;

  assign a_src_busy = r_pend[a_source];
  assign pend       = r_pend;
  assign count      = r_count;
  assign err_pulse  = r_err_pulse;
  assign err_sticky = r_err_sticky;

  // Head entry drives the response bus directly
  assign w_head      = r_mem[r_rptr];
  assign rsp_opcode  = w_head.opcode;
  assign rsp_source  = w_head.source;
  assign rsp_data    = w_head.data;
  assign rsp_denied  = w_head.denied;
  assign rsp_corrupt = w_head.corrupt;

  // Pack the incoming beat for storage
  always_comb begin
    w_din         = '0;
    w_din.opcode  = d_opcode;
    w_din.source  = d_source;
    w_din.data    = d_data;
    w_din.denied  = d_denied;
    w_din.corrupt = d_corrupt;
  end

  // Outstanding table update: a legal response clears, a new request sets (set wins)
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_legal) begin
      w_pend_nxt[d_source] = 1'b0;
    end
    if (a_fire) begin
      w_pend_nxt[a_source] = 1'b1;
    end
  end

  // FIFO storage write on a legal accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_legal) begin
      r_mem[r_wptr] <= w_din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_legal) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_deq) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
    end
  end

  // Occupancy: unchanged on simultaneous enqueue and dequeue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      unique case ({w_legal, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Outstanding-source table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  // Error flags: pulse one cycle after the offending beat; sticky holds until
  // cleared, and neither a new error nor a live pulse can be cleared away
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_err_pulse  <= w_err;
      r_err_sticky <= w_err || r_err_pulse || (r_err_sticky && !err_clr);
    end
  end

endmodule

// File: tb/tb_tl_d_resp_buffer.sv
// Self-checking bench for tl_d_resp_buffer: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_tl_d_resp_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SRC_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NSRC   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              a_fire = 1'b0;
  logic [SRC_W-1:0]  a_source = '0;
  logic              a_src_busy;
  logic              d_valid = 1'b0;
  logic              d_ready;
  logic [2:0]        d_opcode = '0;
  logic [SRC_W-1:0]  d_source = '0;
  logic [DATA_W-1:0] d_data = '0;
  logic              d_denied = 1'b0;
  logic              d_corrupt = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [2:0]        rsp_opcode;
  logic [SRC_W-1:0]  rsp_source;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_denied;
  logic              rsp_corrupt;
  logic [2:0]        count;
  logic [NSRC-1:0]   pend;
  logic              err_pulse;
  logic              err_sticky;
  logic              err_clr = 1'b0;

  tl_d_resp_buffer #(.DEPTH(DEPTH), .SRC_W(SRC_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_fire(a_fire), .a_source(a_source), .a_src_busy(a_src_busy),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_source(d_source),
    .d_data(d_data), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_opcode(rsp_opcode),
    .rsp_source(rsp_source), .rsp_data(rsp_data), .rsp_denied(rsp_denied),
    .rsp_corrupt(rsp_corrupt), .count(count), .pend(pend),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]  op;
    logic [3:0]  src;
    logic [31:0] data;
    logic        den;
    logic        cor;
  } ent_t;

  ent_t            m_q[$];
  logic [NSRC-1:0] m_pend = '0;
  bit              m_pulse = 1'b0;
  bit              m_sticky = 1'b0;

  // Model state advances on each rising edge from the inputs present before it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_pend   = '0;
      m_pulse  = 1'b0;
      m_sticky = 1'b0;
    end else begin
      bit   acc, legal, deq, dup, e;
      ent_t n;
      acc   = d_valid && (m_q.size() < DEPTH);
      legal = acc && m_pend[d_source] && (d_opcode <= 3'd1);
      deq   = (m_q.size() > 0) && rsp_ready;
      dup   = a_fire && m_pend[a_source] && !(legal && d_source == a_source);
      e     = (acc && !legal) || dup;
      m_sticky = e || m_pulse || (m_sticky && !err_clr);
      m_pulse  = e;
      if (deq) void'(m_q.pop_front());
      if (legal) begin
        n.op = d_opcode; n.src = d_source; n.data = d_data; n.den = d_denied; n.cor = d_corrupt;
        m_q.push_back(n);
        m_pend[d_source] = 1'b0;
      end
      if (a_fire) m_pend[a_source] = 1'b1;
    end
  end

  // Per-cycle comparison of every observable output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 64'(count), 64'(m_q.size()));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_q.size() != 0));
      chk("d_ready", 64'(d_ready), 64'(m_q.size() != DEPTH));
      chk("pend", 64'(pend), 64'(m_pend));
      chk("a_src_busy", 64'(a_src_busy), 64'(m_pend[a_source]));
      chk("err_pulse", 64'(err_pulse), 64'(m_pulse));
      chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
      if (m_q.size() != 0) begin
        chk("rsp_opcode", 64'(rsp_opcode), 64'(m_q[0].op));
        chk("rsp_source", 64'(rsp_source), 64'(m_q[0].src));
        chk("rsp_data", 64'(rsp_data), 64'(m_q[0].data));
        chk("rsp_denied", 64'(rsp_denied), 64'(m_q[0].den));
        chk("rsp_corrupt", 64'(rsp_corrupt), 64'(m_q[0].cor));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_fire = 1'b0; d_valid = 1'b0; rsp_ready = 1'b0; err_clr = 1'b0;
  endtask

  task automatic issue(input logic [3:0] s);
    a_fire = 1'b1; a_source = s;
    tick();
    a_fire = 1'b0;
  endtask

  task automatic beat(input logic [2:0] op, input logic [3:0] s, input logic [31:0] dat);
    d_valid = 1'b1; d_opcode = op; d_source = s; d_data = dat;
    d_denied = 1'b0; d_corrupt = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int i = 0; i < 8 && rsp_valid; i++) tick();
    rsp_ready = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #12;
    chk("reset count", 64'(count), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset d_ready", 64'(d_ready), 64'd1);
    chk("reset err_sticky", 64'(err_sticky), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // 1: basic request/response
    issue(4'd3);
    chk("t1 pend3 set", 64'(pend[3]), 64'd1);
    beat(3'd1, 4'd3, 32'hDEADBEEF);
    tick();
    d_valid = 1'b0;
    chk("t1 rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1 rsp_data", 64'(rsp_data), 64'hDEADBEEF);
    chk("t1 pend3 clr", 64'(pend[3]), 64'd0);
    drain();
    chk("t1 empty", 64'(count), 64'd0);

    // 2: fill to DEPTH, 5th beat stalls until one pop
    for (int i = 0; i < 5; i++) issue(4'(i));
    for (int i = 0; i < 4; i++) begin
      beat(3'd0, 4'(i), 32'(i + 16));
      tick();
    end
    beat(3'd0, 4'd4, 32'd20);
    tick(); tick();
    chk("t2 count full", 64'(count), 64'd4);
    chk("t2 d_ready", 64'(d_ready), 64'd0);
    chk("t2 pend4 held", 64'(pend[4]), 64'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t2 count after pop", 64'(count), 64'd3);
    tick();
    d_valid = 1'b0;
    chk("t2 count refill", 64'(count), 64'd4);
    chk("t2 pend4 clr", 64'(pend[4]), 64'd0);
    chk("t2 head data", 64'(rsp_data), 64'd17);
    drain();

    // 3: unexpected source dropped
    beat(3'd1, 4'd7, 32'h1234);
    tick();
    d_valid = 1'b0;
    chk("t3 err_pulse", 64'(err_pulse), 64'd1);
    chk("t3 count", 64'(count), 64'd0);
    tick();
    chk("t3 pulse gone", 64'(err_pulse), 64'd0);
    chk("t3 sticky held", 64'(err_sticky), 64'd1);
    clear_err();
    chk("t3 sticky clr", 64'(err_sticky), 64'd0);

    // 4: bad opcode for an outstanding source
    issue(4'd2);
    beat(3'd4, 4'd2, 32'h55);
    tick();
    d_valid = 1'b0;
    chk("t4 err_pulse", 64'(err_pulse), 64'd1);
    chk("t4 pend2", 64'(pend[2]), 64'd1);
    chk("t4 count", 64'(count), 64'd0);
    beat(3'd0, 4'd2, 32'h66);
    tick();
    d_valid = 1'b0;
    drain();
    clear_err();

    // 5: same-cycle clear and reissue, then a true duplicate
    issue(4'd5);
    beat(3'd0, 4'd5, 32'h77);
    a_fire = 1'b1; a_source = 4'd5;
    tick();
    d_valid = 1'b0; a_fire = 1'b0;
    chk("t5 pend5", 64'(pend[5]), 64'd1);
    chk("t5 no err", 64'(err_pulse), 64'd0);
    chk("t5 count", 64'(count), 64'd1);
    issue(4'd5);
    chk("t5 dup err", 64'(err_pulse), 64'd1);
    chk("t5 pend5 kept", 64'(pend[5]), 64'd1);
    beat(3'd0, 4'd5, 32'h78);
    tick();
    d_valid = 1'b0;
    drain();
    clear_err();

    // 6: steady push/pop at count=2 across pointer wrap, then async reset
    for (int i = 0; i < 10; i++) issue(4'(i));
    issue(4'd10); issue(4'd11);
    beat(3'd1, 4'd10, 32'd200); tick();
    beat(3'd1, 4'd11, 32'd201); tick();
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      beat(3'd1, 4'(c), 32'(100 + c));
      tick();
      chk("t6 count steady", 64'(count), 64'd2);
    end
    d_valid = 1'b0; rsp_ready = 1'b0;
    chk("t6 head order", 64'(rsp_data), 64'd108);
    #3 rst_n = 1'b0;
    #1;
    chk("t6 rst count", 64'(count), 64'd0);
    chk("t6 rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6 rst pend", 64'(pend), 64'd0);
    tick();
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      logic [3:0] cand[$];
      a_fire = ($urandom_range(0, 2) == 0);
      a_source = 4'($urandom_range(0, 15));
      if (m_pend[a_source] && $urandom_range(0, 9) != 0) a_fire = 1'b0;
      d_valid = ($urandom_range(0, 1) == 1);
      cand.delete();
      for (int s = 0; s < 16; s++) if (m_pend[s]) cand.push_back(4'(s));
      if (cand.size() > 0 && $urandom_range(0, 9) != 0)
        d_source = cand[$urandom_range(0, cand.size() - 1)];
      else
        d_source = 4'($urandom_range(0, 15));
      d_opcode  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      d_data    = $urandom;
      d_denied  = 1'($urandom);
      d_corrupt = 1'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 6);
      err_clr   = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
